register_file_vectorial: RTL and testbench
==========================================

REGISTER_FILE_VECTORIAL -- requirements
Module: register_file_vectorial

Interface
REQ-001 SHALL have parameter REGISTERS, default 16, meaning number of vector registers (power of two, at least 2).
REQ-002 SHALL have parameter LANES, default 4, meaning number of lanes per vector register.
REQ-003 SHALL have parameter WIDTH, default 32, meaning bits per lane.
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning 1 hardwires register 0 to all-zero and 0 makes register 0 a normal register.
REQ-005 SHALL define AW = ceil(log2(REGISTERS)) and VW = LANES*WIDTH, with lane k occupying bits [k*WIDTH +: WIDTH].
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 we3  in  1  write enable.
REQ-009 a3  in  AW  write address.
REQ-010 wd3  in  VW  write data.
REQ-011 mask3  in  LANES  per-lane write mask; bit k enables lane k.
REQ-012 a1, a2  in  AW each  read addresses.
REQ-013 rd1, rd2  out  VW each  read data.
REQ-014 lock_we  in  1  marks register lock_a as pending (result in flight).
REQ-015 lock_a  in  AW  register to mark pending.
REQ-016 hz1, hz2  out  1 each  pending flag of register a1 / a2.
REQ-017 busy  out  REGISTERS  full pending-flag vector; bit i belongs to register i.

Function
REQ-018 Storage SHALL be REGISTERS x VW bits, and the only write path SHALL be clocked.
REQ-019 A write (we3=1, rst=0) SHALL update at the clock edge exactly those lanes of register a3 whose mask3 bit is 1; the other lanes SHALL hold.
REQ-020 we3=1 with mask3=0 SHALL change no storage but SHALL still clear busy[a3] per REQ-025.
REQ-021 Reads SHALL be combinational with zero-cycle latency from a1/a2 to rd1/rd2.
REQ-022 Bypass: when we3=1 and a1==a3, each rd1 lane whose mask3 bit is 1 SHALL show wd3's lane in the same cycle, and the other lanes SHALL show stored data; rd2 SHALL behave the same way.
REQ-023 With ZERO_REG=1, reads of address 0 SHALL return 0 regardless of bypass, writes to register 0 SHALL be discarded, and busy[0] SHALL stay 0.
REQ-024 lock_we=1 SHALL set busy[lock_a] at the clock edge.
REQ-025 we3=1 SHALL clear busy[a3] at the clock edge, whatever the mask.
REQ-026 When lock_we=1 and we3=1 target the same register in one cycle, set SHALL win and busy SHALL end at 1.
REQ-027 When lock_we and we3 target different registers, both updates SHALL take effect.
REQ-028 hz1 SHALL equal busy[a1] and hz2 SHALL equal busy[a2], combinationally from registered busy, and bypass SHALL NOT mask them.
REQ-029 Both read ports SHALL allow the same address, including a3, with identical results.
REQ-030 Addresses SHALL be full-range decoded, with no out-of-range case for power-of-two REGISTERS.

Reset
REQ-031 rst=1 at a clock edge SHALL clear all storage lanes and all busy bits to 0 in that single cycle.
REQ-032 rst SHALL take priority over we3 and lock_we in the same cycle, so that neither the write nor the lock takes effect.
REQ-033 During rst=1, the read path and bypass SHALL stay combinational.
REQ-034 The first edge after rst falls SHALL accept writes and locks normally.
REQ-035 Asserting rst mid-operation SHALL discard pending locks without any other side effect.

Verification
REQ-036 Reset clear: write 0xDEADBEEF to all lanes of r5, pulse rst for 1 cycle, read a1=5 -> rd1=0 and busy=0.
REQ-037 Lane mask: r3=0x11111111 in all lanes, then write wd3 lanes=0xAAAAAAAA with mask3=4'b0101 -> r3 lanes {3..0} = {0x11111111, 0xAAAAAAAA, 0x11111111, 0xAAAAAAAA}.
REQ-038 Bypass: r7 holds 0x1 in all lanes; in the same cycle set we3=1, a3=7, a1=7, wd3 lanes=0x2, mask3=4'b0011 -> rd1 lanes {0x1, 0x1, 0x2, 0x2} before the edge.
REQ-039 Zero register: ZERO_REG=1, write 0xFFFFFFFF to r0 and lock r0 -> rd1(a1=0)=0 and busy[0]=0; with ZERO_REG=0 -> rd1=0xFFFFFFFF.
REQ-040 Scoreboard: lock r9 -> hz1=1 for a1=9; we3=1, a3=9 -> hz1=0 next cycle; lock r9 and write r9 in the same cycle -> busy[9]=1.
REQ-041 Reset priority: rst=1 with we3=1 (a3=4) and lock_we=1 (lock_a=4) on the same edge -> r4=0 and busy[4]=0 afterwards.

Source files
------------

// File: rtl/register_file_vectorial.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_vectorial
//  Description : Vector register file. REGISTERS entries of LANES x WIDTH bits
//                with one per-lane masked write port, two combinational read
//                ports with same-cycle write bypass, and a per-register
//                pending (busy) scoreboard with lock/clear.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      : clock, all state updates on rising edge
//    rst      : synchronous active-high reset (clears storage and busy)
//    we3      : write enable
//    a3       : write address
//    wd3      : write data, lane k at [k*WIDTH +: WIDTH]
//    mask3    : per-lane write mask, bit k enables lane k
//    a1, a2   : read addresses
//    rd1, rd2 : read data (combinational, bypassed from the write port)
//    lock_we  : mark register lock_a as pending
//    lock_a   : register to mark pending
//    hz1, hz2 : pending flag of register a1 / a2
//    busy     : full pending-flag vector, bit i belongs to register i
// ============================================================================
module register_file_vectorial #(
    parameter  int REGISTERS = 16,
    parameter  int LANES     = 4,
    parameter  int WIDTH     = 32,
    parameter  int ZERO_REG  = 1,
    localparam int AW        = $clog2(REGISTERS),
    localparam int VW        = LANES * WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we3,
    input  logic [AW-1:0]        a3,
    input  logic [VW-1:0]        wd3,
    input  logic [LANES-1:0]     mask3,
    input  logic [AW-1:0]        a1,
    input  logic [AW-1:0]        a2,
    output logic [VW-1:0]        rd1,
    output logic [VW-1:0]        rd2,
    input  logic                 lock_we,
    input  logic [AW-1:0]        lock_a,
    output logic                 hz1,
    output logic                 hz2,
    output logic [REGISTERS-1:0] busy
);

    // Stored contents of every register, gathered for the read muxes.
    logic [VW-1:0]        w_mem [REGISTERS];
    logic [AW-1:0]        w_rd_addr [2];
    logic [VW-1:0]        w_rd_data [2];

    logic [REGISTERS-1:0] busy_d;
    logic [REGISTERS-1:0] busy_q;

    // ------------------------------------------------------------------------
    // Storage: one row per register, each with its own lane-merging next state.
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < REGISTERS; i++) begin : g_reg
            logic [VW-1:0] row_d;
            logic [VW-1:0] row_q;
            logic          w_row_we;

            // Register 0 never accepts writes when it is hardwired to zero;
            // its row then simply stays at its reset value.
            assign w_row_we = we3 && (a3 == AW'(i)) && !((ZERO_REG != 0) && (i == 0));

            always_comb begin
                row_d = row_q;
                if (w_row_we) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (mask3[k]) begin
                            row_d[k*WIDTH +: WIDTH] = wd3[k*WIDTH +: WIDTH];
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    row_q <= '0;
                end else begin
                    row_q <= row_d;
                end
            end

            assign w_mem[i] = row_q;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Read ports: stored data, overridden lane-by-lane by an in-flight write
    // to the same address, and forced to zero for the hardwired register.
    // ------------------------------------------------------------------------
    assign w_rd_addr[0] = a1;
    assign w_rd_addr[1] = a2;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rd
            logic [VW-1:0] w_data;

            always_comb begin
                w_data = w_mem[w_rd_addr[p]];
                if (we3 && (w_rd_addr[p] == a3)) begin
                    for (int k = 0; k < LANES; k++) begin
                        if (mask3[k]) begin
                            w_data[k*WIDTH +: WIDTH] = wd3[k*WIDTH +: WIDTH];
                        end
                    end
                end
                if ((ZERO_REG != 0) && (w_rd_addr[p] == '0)) begin
                    w_data = '0;
                end
            end

            assign w_rd_data[p] = w_data;
        end
    endgenerate

    assign rd1 = w_rd_data[0];
    assign rd2 = w_rd_data[1];

    // ------------------------------------------------------------------------
    // Pending scoreboard. The lock is applied after the write-clear so that a
    // lock and a write to the same register leave it pending.
    // ------------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (we3) begin
            busy_d[a3] = 1'b0;
        end
        if (lock_we) begin
            busy_d[lock_a] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Hazard flags come from the registered scoreboard only; bypass does not
    // hide a pending register.
    assign busy = busy_q;
    assign hz1  = busy_q[a1];
    assign hz2  = busy_q[a2];

endmodule
`default_nettype wire

// File: tb/tb_register_file_vectorial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_vectorial
//  Description : Self-checking bench for register_file_vectorial. Two
//                instances share stimulus: one with register 0 hardwired to
//                zero, one with register 0 as a normal register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_vectorial;

    localparam int REGS = 16;
    localparam int LN   = 4;
    localparam int WD   = 32;
    localparam int AWB  = 4;
    localparam int VWB  = LN * WD;

    logic            clk = 1'b0;
    logic            rst;
    logic            we3;
    logic [AWB-1:0]  a3;
    logic [VWB-1:0]  wd3;
    logic [LN-1:0]   mask3;
    logic [AWB-1:0]  a1;
    logic [AWB-1:0]  a2;
    logic            lock_we;
    logic [AWB-1:0]  lock_a;

    logic [VWB-1:0]  rd1_z, rd2_z, rd1_n, rd2_n;
    logic            hz1_z, hz2_z, hz1_n, hz2_n;
    logic [REGS-1:0] busy_z, busy_n;

    int total = 0;
    int bad   = 0;

    // Reference state: [instance][register][lane]; instance 0 has ZERO_REG=1.
    logic [WD-1:0] m_mem  [2][REGS][LN];
    bit            m_busy [2][REGS];

    always #5 clk = ~clk;

    register_file_vectorial #(
        .REGISTERS(REGS), .LANES(LN), .WIDTH(WD), .ZERO_REG(1)
    ) u_dut_z (
        .clk(clk), .rst(rst), .we3(we3), .a3(a3), .wd3(wd3), .mask3(mask3),
        .a1(a1), .a2(a2), .rd1(rd1_z), .rd2(rd2_z),
        .lock_we(lock_we), .lock_a(lock_a),
        .hz1(hz1_z), .hz2(hz2_z), .busy(busy_z)
    );

    register_file_vectorial #(
        .REGISTERS(REGS), .LANES(LN), .WIDTH(WD), .ZERO_REG(0)
    ) u_dut_n (
        .clk(clk), .rst(rst), .we3(we3), .a3(a3), .wd3(wd3), .mask3(mask3),
        .a1(a1), .a2(a2), .rd1(rd1_n), .rd2(rd2_n),
        .lock_we(lock_we), .lock_a(lock_a),
        .hz1(hz1_n), .hz2(hz2_n), .busy(busy_n)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [VWB-1:0] exp_rd(input int inst, input logic [AWB-1:0] a);
        logic [VWB-1:0] v;
        for (int k = 0; k < LN; k++) begin
            if (we3 && a == a3 && mask3[k]) v[k*WD +: WD] = wd3[k*WD +: WD];
            else                            v[k*WD +: WD] = m_mem[inst][a][k];
        end
        if (inst == 0 && a == 0) v = '0;
        return v;
    endfunction

    function automatic logic [REGS-1:0] exp_busy(input int inst);
        logic [REGS-1:0] v;
        for (int r = 0; r < REGS; r++) v[r] = m_busy[inst][r];
        return v;
    endfunction

    task automatic model_edge();
        for (int inst = 0; inst < 2; inst++) begin
            if (rst) begin
                for (int r = 0; r < REGS; r++) begin
                    m_busy[inst][r] = 1'b0;
                    for (int k = 0; k < LN; k++) m_mem[inst][r][k] = '0;
                end
            end else begin
                if (we3 && !(inst == 0 && a3 == 0))
                    for (int k = 0; k < LN; k++)
                        if (mask3[k]) m_mem[inst][a3][k] = wd3[k*WD +: WD];
                if (we3) m_busy[inst][a3] = 1'b0;
                if (lock_we && !(inst == 0 && lock_a == 0)) m_busy[inst][lock_a] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we3 = 1'b0; a3 = '0; wd3 = '0; mask3 = '0;
        lock_we = 1'b0; lock_a = '0;
    endtask

    task automatic wr(input logic [AWB-1:0] a, input logic [VWB-1:0] d, input logic [LN-1:0] m);
        we3 = 1'b1; a3 = a; wd3 = d; mask3 = m;
        tick();
        we3 = 1'b0; mask3 = '0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        idle(); a1 = 4'd5; a2 = 4'd6;
        rst = 1'b1; tick(); rst = 1'b0; #1;
        total++;
        if (busy_z !== '0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy_z); end
        wr(4'd5, {4{32'hDEADBEEF}}, 4'hF);
        lock_we = 1'b1; lock_a = 4'd6; tick(); lock_we = 1'b0; #1;
        total++;
        if (rd1_z !== {4{32'hDEADBEEF}}) begin bad++; $display("FAIL r5_written got=%h exp=%h", rd1_z, {4{32'hDEADBEEF}}); end
        total++;
        if (hz2_z !== 1'b1) begin bad++; $display("FAIL r6_locked got=%b exp=1", hz2_z); end
        rst = 1'b1; tick(); rst = 1'b0; #1;
        total++;
        if (rd1_z !== '0) begin bad++; $display("FAIL reset_r5 got=%h exp=0", rd1_z); end
        total++;
        if (busy_z !== '0) begin bad++; $display("FAIL reset_busy_after got=%h exp=0", busy_z); end
    endtask

    task automatic test_lane_mask();
        idle();
        wr(4'd3, {4{32'h11111111}}, 4'hF);
        wr(4'd3, {4{32'hAAAAAAAA}}, 4'b0101);
        a1 = 4'd3; a2 = 4'd3; #1;
        total++;
        if (rd1_z !== {32'h11111111, 32'hAAAAAAAA, 32'h11111111, 32'hAAAAAAAA}) begin
            bad++; $display("FAIL lane_mask_rd1 got=%h exp=%h", rd1_z,
                            {32'h11111111, 32'hAAAAAAAA, 32'h11111111, 32'hAAAAAAAA});
        end
        total++;
        if (rd2_z !== rd1_z || rd2_z !== {32'h11111111, 32'hAAAAAAAA, 32'h11111111, 32'hAAAAAAAA}) begin
            bad++; $display("FAIL lane_mask_rd2 got=%h rd1=%h", rd2_z, rd1_z);
        end
    endtask

    task automatic test_bypass();
        idle();
        wr(4'd7, {4{32'h1}}, 4'hF);
        we3 = 1'b1; a3 = 4'd7; a1 = 4'd7; a2 = 4'd7; wd3 = {4{32'h2}}; mask3 = 4'b0011; #1;
        total++;
        if (rd1_z !== {32'h1, 32'h1, 32'h2, 32'h2}) begin
            bad++; $display("FAIL bypass_rd1 got=%h exp=%h", rd1_z, {32'h1, 32'h1, 32'h2, 32'h2});
        end
        total++;
        if (rd2_z !== {32'h1, 32'h1, 32'h2, 32'h2}) begin
            bad++; $display("FAIL bypass_rd2 got=%h exp=%h", rd2_z, {32'h1, 32'h1, 32'h2, 32'h2});
        end
        tick(); we3 = 1'b0; mask3 = '0; #1;
        total++;
        if (rd1_z !== {32'h1, 32'h1, 32'h2, 32'h2}) begin
            bad++; $display("FAIL bypass_stored got=%h exp=%h", rd1_z, {32'h1, 32'h1, 32'h2, 32'h2});
        end
    endtask

    task automatic test_zero_reg();
        idle();
        we3 = 1'b1; a3 = 4'd0; wd3 = {4{32'hFFFFFFFF}}; mask3 = 4'hF;
        lock_we = 1'b1; lock_a = 4'd0; a1 = 4'd0; #1;
        total++;
        if (rd1_z !== '0) begin bad++; $display("FAIL zero_bypass got=%h exp=0", rd1_z); end
        tick(); idle(); #1;
        total++;
        if (rd1_z !== '0) begin bad++; $display("FAIL zero_rd got=%h exp=0", rd1_z); end
        total++;
        if (busy_z[0] !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b exp=0", busy_z[0]); end
        total++;
        if (rd1_n !== {4{32'hFFFFFFFF}}) begin bad++; $display("FAIL nonzero_rd got=%h exp=%h", rd1_n, {4{32'hFFFFFFFF}}); end
        total++;
        if (busy_n[0] !== 1'b1) begin bad++; $display("FAIL nonzero_busy got=%b exp=1", busy_n[0]); end
    endtask

    task automatic test_scoreboard();
        idle(); a1 = 4'd9; a2 = 4'd10;
        lock_we = 1'b1; lock_a = 4'd9; tick(); lock_we = 1'b0; #1;
        total++;
        if (hz1_z !== 1'b1) begin bad++; $display("FAIL lock_hz1 got=%b exp=1", hz1_z); end
        we3 = 1'b1; a3 = 4'd9; mask3 = 4'b0000; wd3 = {4{32'h5A5A5A5A}}; #1;
        total++;
        if (hz1_z !== 1'b1) begin bad++; $display("FAIL hz1_not_bypassed got=%b exp=1", hz1_z); end
        tick(); we3 = 1'b0; #1;
        total++;
        if (hz1_z !== 1'b0) begin bad++; $display("FAIL clear_hz1 got=%b exp=0", hz1_z); end
        we3 = 1'b1; a3 = 4'd9; mask3 = 4'hF; lock_we = 1'b1; lock_a = 4'd9;
        tick(); idle(); #1;
        total++;
        if (busy_z[9] !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", busy_z[9]); end
        we3 = 1'b1; a3 = 4'd9; mask3 = 4'hF; lock_we = 1'b1; lock_a = 4'd10;
        tick(); idle(); #1;
        total++;
        if (busy_z[10:9] !== 2'b10 || hz2_z !== 1'b1) begin
            bad++; $display("FAIL split_lock_clear got=%b hz2=%b exp=10/1", busy_z[10:9], hz2_z);
        end
    endtask

    task automatic test_reset_priority();
        idle(); a1 = 4'd4;
        wr(4'd4, {4{32'h0BADF00D}}, 4'hF);
        rst = 1'b1; we3 = 1'b1; a3 = 4'd4; wd3 = {4{32'h12345678}}; mask3 = 4'hF;
        lock_we = 1'b1; lock_a = 4'd4; #1;
        total++;
        if (rd1_z !== {4{32'h12345678}}) begin bad++; $display("FAIL bypass_in_reset got=%h exp=%h", rd1_z, {4{32'h12345678}}); end
        tick(); idle(); #1;
        total++;
        if (rd1_z !== '0) begin bad++; $display("FAIL rst_prio_r4 got=%h exp=0", rd1_z); end
        total++;
        if (busy_z[4] !== 1'b0) begin bad++; $display("FAIL rst_prio_busy got=%b exp=0", busy_z[4]); end
        wr(4'd4, {4{32'hCAFEF00D}}, 4'hF); #1;
        total++;
        if (rd1_z !== {4{32'hCAFEF00D}}) begin bad++; $display("FAIL post_reset_write got=%h exp=%h", rd1_z, {4{32'hCAFEF00D}}); end
    endtask

    task automatic test_random();
        logic [VWB-1:0] er;
        logic [REGS-1:0] eb;
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 39) == 0);
            we3     = $urandom_range(0, 1);
            a3      = 4'($urandom_range(0, REGS-1));
            wd3     = {$urandom, $urandom, $urandom, $urandom};
            mask3   = 4'($urandom_range(0, 15));
            lock_we = ($urandom_range(0, 2) == 0);
            lock_a  = ($urandom_range(0, 3) == 0) ? a3 : 4'($urandom_range(0, REGS-1));
            a1      = ($urandom_range(0, 2) == 0) ? a3 : 4'($urandom_range(0, REGS-1));
            a2      = ($urandom_range(0, 3) == 0) ? a1 : 4'($urandom_range(0, REGS-1));
            #1;
            for (int inst = 0; inst < 2; inst++) begin
                er = exp_rd(inst, a1);
                total++;
                if ((inst == 0 ? rd1_z : rd1_n) !== er) begin
                    bad++; $display("FAIL rand_rd1 inst=%0d cyc=%0d got=%h exp=%h", inst, n, (inst == 0 ? rd1_z : rd1_n), er);
                end
                er = exp_rd(inst, a2);
                total++;
                if ((inst == 0 ? rd2_z : rd2_n) !== er) begin
                    bad++; $display("FAIL rand_rd2 inst=%0d cyc=%0d got=%h exp=%h", inst, n, (inst == 0 ? rd2_z : rd2_n), er);
                end
                eb = exp_busy(inst);
                total++;
                if ((inst == 0 ? busy_z : busy_n) !== eb) begin
                    bad++; $display("FAIL rand_busy inst=%0d cyc=%0d got=%h exp=%h", inst, n, (inst == 0 ? busy_z : busy_n), eb);
                end
                total++;
                if ((inst == 0 ? {hz1_z, hz2_z} : {hz1_n, hz2_n}) !== {eb[a1], eb[a2]}) begin
                    bad++; $display("FAIL rand_hz inst=%0d cyc=%0d got=%b%b exp=%b%b", inst, n,
                                    (inst == 0 ? hz1_z : hz1_n), (inst == 0 ? hz2_z : hz2_n), eb[a1], eb[a2]);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle(); a1 = '0; a2 = '0;
        test_reset();
        test_lane_mask();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_reset_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
